peri_bus_bridge: RTL and testbench

Upstream neighbour of the memory-mapped peripherals (LEDs, GPIO, UART, timer).
- Accepts single-cycle read/write requests from the CPU data port and decodes the address into one of NUM_SLAVES fixed-size slots.
- Drives the selected peripheral's read/write strobes, waits for its response, and returns data plus a one-cycle response to the CPU.
- Flags decode errors, protocol errors and timeouts.

---
 rtl/peri_bus_bridge_pkg.sv | 26 ++
 rtl/peri_addr_decoder.sv | 24 ++
 rtl/peri_bus_bridge.sv | 146 ++++++++++++++
 tb/tb_peri_bus_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_bus_bridge_pkg.sv
// Shared definitions for the peripheral bus bridge and its address decoder.
// State encodings, error data value, default address map and fixed slot numbers.
package peri_bus_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } state_e;

  localparam logic [31:0] ERR_READ_DATA = 32'h0000_0000;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam int unsigned DEFAULT_SLOT_BITS = 8;

  localparam int unsigned SLOT_LED   = 0;
  localparam int unsigned SLOT_GPIO  = 1;
  localparam int unsigned SLOT_UART  = 2;
  localparam int unsigned SLOT_TIMER = 3;

  // A single slot still needs a 1-bit index to keep vector widths legal.
  function automatic int unsigned slot_width(int unsigned num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/peri_addr_decoder.sv
// Combinational address decoder: maps a byte address onto a fixed-size slot index.
// Addresses below the base wrap through the unsigned subtraction and decode out of range.
module peri_addr_decoder
  import peri_bus_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned SLOT_BITS  = DEFAULT_SLOT_BITS,
  localparam int unsigned SLOT_W    = slot_width(NUM_SLAVES)
) (
  input  logic [31:0]       address,
  output logic [SLOT_W-1:0] slot,
  output logic              in_range
);

  logic [31:0] offset;
  logic [31:0] index;

  assign offset   = address - BASE_ADDR;
  assign index    = offset >> SLOT_BITS;
  assign in_range = index < NUM_SLAVES;
  assign slot     = index[SLOT_W-1:0];

endmodule

// File: rtl/peri_bus_bridge.sv
// CPU data-port to memory-mapped peripheral bridge (IDLE -> ACCESS -> DONE).
// Optional access timeout enabled by defining PERI_BUS_TIMEOUT_EN.
module peri_bus_bridge
  import peri_bus_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int unsigned SLOT_BITS      = DEFAULT_SLOT_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [31:0]              cpu_address,
  input  logic [31:0]              cpu_write_data,
  output logic [31:0]              cpu_read_data,
  output logic                     cpu_response,
  output logic                     cpu_error,
  output logic [NUM_SLAVES-1:0]    per_read,
  output logic [NUM_SLAVES-1:0]    per_write,
  output logic [31:0]              per_address,
  output logic [31:0]              per_write_data,
  input  logic [32*NUM_SLAVES-1:0] per_read_data,
  input  logic [NUM_SLAVES-1:0]    per_response
);

  localparam int unsigned SLOT_W = slot_width(NUM_SLAVES);

  state_e            state_q;
  logic              op_write_q;
  logic [SLOT_W-1:0] slot_q;

  logic [SLOT_W-1:0]     dec_slot;
  logic                  dec_in_range;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  sel_response;
  logic [31:0]           sel_read_data;

  peri_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_BITS (SLOT_BITS)
  ) u_addr_decoder (
    .address (cpu_address),
    .slot    (dec_slot),
    .in_range(dec_in_range)
  );

  assign dec_onehot = NUM_SLAVES'(1) << dec_slot;

  // Only the captured slot's response and data are looked at.
  always_comb begin
    sel_response  = 1'b0;
    sel_read_data = ERR_READ_DATA;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        sel_response  = per_response[i];
        sel_read_data = per_read_data[32*i +: 32];
      end
    end
  end

`ifdef PERI_BUS_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
  logic [TIMER_W-1:0] timer_q;
  logic               timeout;
  assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      op_write_q     <= 1'b0;
      slot_q         <= '0;
      per_read       <= '0;
      per_write      <= '0;
      per_address    <= '0;
      per_write_data <= '0;
      cpu_response   <= 1'b0;
      cpu_error      <= 1'b0;
      cpu_read_data  <= ERR_READ_DATA;
`ifdef PERI_BUS_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      cpu_response  <= 1'b0;
      cpu_error     <= 1'b0;
      cpu_read_data <= ERR_READ_DATA;
      unique case (state_q)
        StIdle: begin
          if (cpu_read && cpu_write) begin
            state_q      <= StDone;
            cpu_response <= 1'b1;
            cpu_error    <= 1'b1;
          end else if (cpu_read || cpu_write) begin
            per_address    <= cpu_address;
            per_write_data <= cpu_write_data;
            op_write_q     <= cpu_write;
            slot_q         <= dec_slot;
            if (dec_in_range) begin
              state_q   <= StAccess;
              per_read  <= cpu_read  ? dec_onehot : '0;
              per_write <= cpu_write ? dec_onehot : '0;
`ifdef PERI_BUS_TIMEOUT_EN
              timer_q   <= '0;
`endif
            end else begin
              state_q      <= StDone;
              cpu_response <= 1'b1;
              cpu_error    <= 1'b1;
            end
          end
        end
        StAccess: begin
          if (sel_response) begin
            state_q       <= StDone;
            per_read      <= '0;
            per_write     <= '0;
            cpu_response  <= 1'b1;
            cpu_read_data <= op_write_q ? ERR_READ_DATA : sel_read_data;
          end
`ifdef PERI_BUS_TIMEOUT_EN
          else if (timeout) begin
            state_q      <= StDone;
            per_read     <= '0;
            per_write    <= '0;
            cpu_response <= 1'b1;
            cpu_error    <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peri_bus_bridge.sv
// Scoreboard bench for peri_bus_bridge: directed requests push expected responses,
// a negedge monitor pops and compares whenever cpu_response is seen.
module tb_peri_bus_bridge;

  localparam int NS = 4;

  logic             clk;
  logic             reset;
  logic             cpu_read;
  logic             cpu_write;
  logic [31:0]      cpu_address;
  logic [31:0]      cpu_write_data;
  logic [31:0]      cpu_read_data;
  logic             cpu_response;
  logic             cpu_error;
  logic [NS-1:0]    per_read;
  logic [NS-1:0]    per_write;
  logic [31:0]      per_address;
  logic [31:0]      per_write_data;
  logic [32*NS-1:0] per_read_data;
  logic [NS-1:0]    per_response;

  peri_bus_bridge #(
    .NUM_SLAVES    (NS),
    .BASE_ADDR     (32'h8000_0000),
    .SLOT_BITS     (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_read_data (cpu_read_data),
    .cpu_response  (cpu_response),
    .cpu_error     (cpu_error),
    .per_read      (per_read),
    .per_write     (per_write),
    .per_address   (per_address),
    .per_write_data(per_write_data),
    .per_read_data (per_read_data),
    .per_response  (per_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peripheral model: slot i responds after lat[i] strobe cycles (-1 = never).
  int         lat [NS];
  logic [7:0] cnt [NS];
  assign per_read_data = {32'hDDDD_0003, 32'h1234_5678, 32'hBBBB_0001, 32'hAAAA_0000};

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (per_read[i] || per_write[i]) cnt[i] <= cnt[i] + 8'd1;
      else cnt[i] <= 8'd0;
    end
  end

  always_comb begin
    per_response = '0;
    for (int i = 0; i < NS; i++) begin
      per_response[i] = (per_read[i] || per_write[i]) && (lat[i] >= 0) && (int'(cnt[i]) == lat[i]);
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  int          resp_count = 0;
  int          strobe_cycles;
  logic [NS-1:0] rd_or, wr_or;
  logic [31:0] addr_seen, wdata_seen;

  always @(negedge clk) begin
    exp_t e;
    if (cpu_response) begin
      resp_count++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got response err=%b data=%h expected none", cpu_error,
                 cpu_read_data);
      end else begin
        e = sb.pop_front();
        check("resp_error", {31'b0, cpu_error}, {31'b0, e.err});
        check("resp_data", cpu_read_data, e.data);
        check("resp_latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end else if (!reset) begin
      check("idle_data_zero", cpu_read_data, 32'h0);
    end
    if ((per_read | per_write) != '0) begin
      strobe_cycles++;
      rd_or      |= per_read;
      wr_or      |= per_write;
      addr_seen  = per_address;
      wdata_seen = per_write_data;
      check("strobe_onehot", 32'($countones(per_read | per_write)), 32'd1);
    end
  end

  task automatic wait_resp(int start);
    int n = 0;
    while (resp_count == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (resp_count == start) begin
      tests++;
      fails++;
      $display("FAIL wait_resp: got no response after %0d cycles expected one", n);
    end
  endtask

  task automatic issue(logic rd, logic wr, logic [31:0] a, logic [31:0] d, bit push,
                       logic err, logic [31:0] data, int latency);
    int start;
    @(posedge clk);
    #1;
    strobe_cycles = 0;
    rd_or         = '0;
    wr_or         = '0;
    addr_seen     = '0;
    wdata_seen    = '0;
    start         = resp_count;
    if (push) sb.push_back('{err: err, data: data, lat: latency, t0: cyc});
    cpu_read       = rd;
    cpu_write      = wr;
    cpu_address    = a;
    cpu_write_data = d;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (push) wait_resp(start);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    for (int i = 0; i < NS; i++) lat[i] = -1;
    reset          = 1'b1;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    cpu_address    = '0;
    cpu_write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_response", {31'b0, cpu_response}, 32'h0);
    check("rst_strobes", {24'b0, per_read, per_write}, 32'h0);
    check("rst_address", per_address, 32'h0);
    check("rst_wdata", per_write_data, 32'h0);

    // LED write, combinational response
    lat[0] = 0;
    issue(1'b0, 1'b1, 32'h8000_0000, 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 2);
    check("led_wr_strobe", {28'b0, wr_or}, 32'h1);
    check("led_rd_strobe", {28'b0, rd_or}, 32'h0);
    check("led_strobe_cycles", 32'(strobe_cycles), 32'd1);
    check("led_wdata", wdata_seen, 32'h0000_00A5);

    // Slot 2 read, response after 3 strobe cycles
    lat[2] = 2;
    issue(1'b1, 1'b0, 32'h8000_0204, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 4);
    check("s2_rd_strobe", {28'b0, rd_or}, 32'h4);
    check("s2_strobe_cycles", 32'(strobe_cycles), 32'd3);
    check("s2_address", addr_seen, 32'h8000_0204);

    // LED read
    issue(1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b1, 1'b0, 32'hAAAA_0000, 2);

    // Decode errors: above the top slot and below the base
    issue(1'b1, 1'b0, 32'h8000_0400, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    check("dec_hi_strobes", 32'(strobe_cycles), 32'd0);
    issue(1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    check("dec_lo_strobes", 32'(strobe_cycles), 32'd0);

    // Protocol error
    issue(1'b1, 1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h0, 1);
    check("proto_strobes", 32'(strobe_cycles), 32'd0);

    // Response on the 16th access cycle completes normally in either build
    lat[3] = 15;
    issue(1'b1, 1'b0, 32'h8000_0300, 32'h0, 1'b1, 1'b0, 32'hDDDD_0003, 17);
    check("s3_strobe_cycles", 32'(strobe_cycles), 32'd16);

    // Slot 1 never responds
    lat[1] = -1;
`ifdef PERI_BUS_TIMEOUT_EN
    issue(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b1, 1'b1, 32'h0, 17);
    check("to_strobe_cycles", 32'(strobe_cycles), 32'd16);
    check("to_rd_strobe", {28'b0, rd_or}, 32'h2);
`else
    start = resp_count;
    issue(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("hang_no_resp", 32'(resp_count - start), 32'd0);
    check("hang_strobe", {28'b0, per_read}, 32'h2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
`endif

    // Reset in the middle of an access
    start = resp_count;
    issue(1'b1, 1'b0, 32'h8000_0104, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("pre_rst_strobe", {28'b0, per_read}, 32'h2);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_strobes", {24'b0, per_read, per_write}, 32'h0);
    repeat (5) @(posedge clk);
    check("mid_rst_no_resp", 32'(resp_count - start), 32'd0);

    // Fresh request after reset
    lat[1] = 1;
    issue(1'b0, 1'b1, 32'h8000_0104, 32'h0000_CAFE, 1'b1, 1'b0, 32'h0, 3);
    check("fresh_wr_strobe", {28'b0, wr_or}, 32'h2);
    check("fresh_strobe_cycles", 32'(strobe_cycles), 32'd2);
    check("fresh_wdata", wdata_seen, 32'h0000_CAFE);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
